// File: rtl/rhythm_pkg.sv
// Shared note-chart and judgement types for the lane readers, chart ROMs and score block.
package rhythm_pkg;

  localparam int unsigned NOTE_TIME_W = 14;
  localparam int unsigned COMBO_W     = 10;
  localparam int unsigned COMBO_MAX   = 999;

  typedef enum logic [1:0] {
    TAP        = 2'b00,
    HOLD_START = 2'b01,
    HOLD_END   = 2'b10,
    END        = 2'b11
  } note_type_e;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    PERFECT = 2'b01,
    GOOD    = 2'b10,
    MISS    = 2'b11
  } grade_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } lane_state_e;

endpackage

// File: rtl/lane_note_judge_if.sv
// Lane bundle: chart ROM port, key/frame inputs and judgement outputs for one lane.
interface lane_note_judge_if import rhythm_pkg::*; #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned TIME_W = 14
);
  logic               frame_tick;
  logic               start;
  logic               key_down;
  logic [15:0]        note_word;
  logic [ADDR_W-1:0]  rom_addr;
  logic [TIME_W-1:0]  song_time;
  logic               judge_valid;
  grade_e             grade;
  logic [COMBO_W-1:0] combo;
  logic               hold_active;
  logic               lane_done;

  modport master (
    output frame_tick, start, key_down, note_word,
    input  rom_addr, song_time, judge_valid, grade, combo, hold_active, lane_done
  );

  modport slave (
    input  frame_tick, start, key_down, note_word,
    output rom_addr, song_time, judge_valid, grade, combo, hold_active, lane_done
  );
endinterface

// File: rtl/judge_window.sv
// Signed time difference between song time and a note, classified into timing windows.
module judge_window import rhythm_pkg::*; #(
  parameter int unsigned TIME_W    = 14,
  parameter int unsigned PERFECT_W = 3,
  parameter int unsigned GOOD_W    = 6
) (
  input  logic [TIME_W-1:0] song_time,
  input  logic [TIME_W-1:0] note_time,
  output grade_e            grade_c,
  output logic              early_c,
  output logic              late_c,
  output logic              reached_c
);

  logic signed [TIME_W:0] dt;
  logic        [TIME_W:0] mag;

  always_comb begin
    dt        = $signed({1'b0, song_time}) - $signed({1'b0, note_time});
    mag       = dt[TIME_W] ? $unsigned(-dt) : $unsigned(dt);
    reached_c = !dt[TIME_W];
    grade_c   = NONE;
    if (mag <= (TIME_W+1)'(PERFECT_W)) begin
      grade_c = PERFECT;
    end else if (mag <= (TIME_W+1)'(GOOD_W)) begin
      grade_c = GOOD;
    end
    early_c = dt[TIME_W] && (grade_c == NONE);
    late_c  = !dt[TIME_W] && (grade_c == NONE);
  end

endmodule

// File: rtl/lane_note_judge.sv
// One lane's chart reader: walks the note ROM against song time and grades tap/hold key presses.
module lane_note_judge import rhythm_pkg::*; #(
  parameter int unsigned     ADDR_W    = 8,
  parameter int unsigned     TIME_W    = NOTE_TIME_W,
  parameter int unsigned     PERFECT_W = 3,
  parameter int unsigned     GOOD_W    = 6,
  parameter logic [TIME_W-1:0] END_TIME = 14'h16D3
) (
  input logic              Clk,
  input logic              Reset_n,
  lane_note_judge_if.slave bus
);

  lane_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic               valid_q, valid_d;
  grade_e             grade_q, grade_d;
  logic               hold_q, hold_d;
  logic               done_q, done_d;
  logic               key_q;

  note_type_e         head_type;
  logic [TIME_W-1:0]  head_time;
  logic               key_press, key_release;
  grade_e             jw_grade, judged;
  logic               jw_early, jw_late, jw_reached;
  logic [1:0]         step;

  assign head_type   = note_type_e'(bus.note_word[15:14]);
  assign head_time   = bus.note_word[TIME_W-1:0];
  assign key_press   = bus.key_down & ~key_q;
  assign key_release = ~bus.key_down & key_q;

  judge_window #(
    .TIME_W    (TIME_W),
    .PERFECT_W (PERFECT_W),
    .GOOD_W    (GOOD_W)
  ) u_window (
    .song_time (time_q),
    .note_time (head_time),
    .grade_c   (jw_grade),
    .early_c   (jw_early),
    .late_c    (jw_late),
    .reached_c (jw_reached)
  );

  // Next-state: at most one judgement and one address advance per cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    time_d  = time_q;
    combo_d = combo_q;
    valid_d = 1'b0;
    grade_d = NONE;
    hold_d  = hold_q;
    done_d  = done_q;
    judged  = NONE;
    step    = 2'd0;

    if ((state_q == S_WAIT || state_q == S_HOLD) && bus.frame_tick && (time_q != '1)) begin
      time_d = time_q + 1'b1;
    end

    unique case (state_q)
      S_WAIT: begin
        if (head_type == END || head_time >= END_TIME || addr_q == '1) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (head_type == HOLD_END) begin
          step = 2'd1;  // orphan end entry: skip it silently
        end else if (jw_late) begin
          judged = MISS;
          step   = (head_type == HOLD_START) ? 2'd2 : 2'd1;
        end else if (key_press && !jw_early) begin
          judged = jw_grade;
          step   = 2'd1;
          if (head_type == HOLD_START) begin
            state_d = S_HOLD;
            hold_d  = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (bus.key_down && jw_reached) begin
          judged = PERFECT;
        end else if (key_release) begin
          judged = (jw_grade == NONE) ? MISS : jw_grade;
        end
        if (judged != NONE) begin
          step    = 2'd1;
          state_d = S_WAIT;
          hold_d  = 1'b0;
        end
      end
      default: ;
    endcase

    addr_d = addr_q + ADDR_W'(step);

    if (judged != NONE) begin
      valid_d = 1'b1;
      grade_d = judged;
      if (judged == MISS) begin
        combo_d = '0;
      end else if (combo_q < COMBO_W'(COMBO_MAX)) begin
        combo_d = combo_q + 1'b1;
      end
    end

    if (bus.start) begin
      state_d = S_WAIT;
      addr_d  = '0;
      time_d  = '0;
      combo_d = '0;
      valid_d = 1'b0;
      grade_d = NONE;
      hold_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      time_q  <= '0;
      combo_q <= '0;
      valid_q <= 1'b0;
      grade_q <= NONE;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      key_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      time_q  <= time_d;
      combo_q <= combo_d;
      valid_q <= valid_d;
      grade_q <= grade_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      key_q   <= bus.key_down;
    end
  end

  assign bus.rom_addr    = addr_q;
  assign bus.song_time   = time_q;
  assign bus.combo       = combo_q;
  assign bus.judge_valid = valid_q;
  assign bus.grade       = grade_q;
  assign bus.hold_active = hold_q;
  assign bus.lane_done   = done_q;

endmodule

// File: tb/tb_lane_note_judge.sv
// Directed bench for lane_note_judge: one chart walked through tap, hold, miss, end and reset cases.
module tb_lane_note_judge;
  import rhythm_pkg::*;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [15:0] rom [256];

  lane_note_judge_if #(.ADDR_W(8), .TIME_W(14)) bus ();

  lane_note_judge #(
    .ADDR_W(8), .TIME_W(14), .PERFECT_W(3), .GOOD_W(6), .END_TIME(14'h16D3)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;
  assign bus.note_word = rom[bus.rom_addr];

  function automatic logic [15:0] mk(input logic [1:0] ty, input int t);
    return {ty, 14'(t)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic advance_to(input int t);
    int n;
    n = 0;
    bus.frame_tick = 1'b1;
    while (bus.song_time != 14'(t) && n < 20000) begin
      step();
      n++;
    end
    bus.frame_tick = 1'b0;
    chk("advance_to", 32'(bus.song_time), 32'(t));
  endtask

  task automatic chk_judge(input string tag, input grade_e g, input int addr, input int combo);
    chk({tag, "_valid"}, 32'(bus.judge_valid), 32'(g != NONE));
    chk({tag, "_grade"}, 32'(bus.grade), 32'(g));
    chk({tag, "_addr"},  32'(bus.rom_addr), 32'(addr));
    chk({tag, "_combo"}, 32'(bus.combo), 32'(combo));
  endtask

  task automatic press();
    bus.key_down = 1'b1;
    step();
  endtask

  task automatic release_key();
    bus.key_down = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = mk(2'b11, 0);
    rom[0]  = mk(2'b00, 136);
    rom[1]  = mk(2'b00, 150);
    rom[2]  = mk(2'b00, 160);
    rom[3]  = mk(2'b01, 330);
    rom[4]  = mk(2'b10, 342);
    rom[5]  = mk(2'b01, 400);
    rom[6]  = mk(2'b10, 412);
    rom[7]  = mk(2'b01, 450);
    rom[8]  = mk(2'b10, 470);
    rom[9]  = mk(2'b00, 500);
    rom[10] = mk(2'b00, 14'h16D3);

    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.key_down   = 1'b0;
    #1;
    chk("rst_addr", 32'(bus.rom_addr), 0);
    chk("rst_valid", 32'(bus.judge_valid), 0);
    chk("rst_done", 32'(bus.lane_done), 0);
    step();
    Reset_n = 1'b1;
    bus.frame_tick = 1'b1;
    step();
    step();
    chk("idle_time_frozen", 32'(bus.song_time), 0);
    bus.frame_tick = 1'b0;

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_addr", 32'(bus.rom_addr), 0);

    // Far-early press is ignored
    advance_to(100);
    press();
    chk_judge("early_press", NONE, 0, 0);
    release_key();

    advance_to(142);
    press();
    chk_judge("tap_good_late6", GOOD, 1, 1);
    release_key();
    chk_judge("pulse_clears", NONE, 1, 1);

    advance_to(157);
    step();
    chk_judge("tap_timeout_miss", MISS, 2, 0);

    advance_to(163);
    press();
    chk_judge("tap_perfect_late3", PERFECT, 3, 1);
    release_key();

    // Hold held to its end
    advance_to(330);
    press();
    chk_judge("hold_start_perfect", PERFECT, 4, 2);
    chk("hold_active_set", 32'(bus.hold_active), 1);
    advance_to(342);
    step();
    chk_judge("hold_end_perfect", PERFECT, 5, 3);
    chk("hold_active_clr", 32'(bus.hold_active), 0);
    release_key();

    // Hold released too early
    advance_to(400);
    press();
    chk_judge("hold2_start", PERFECT, 6, 4);
    advance_to(404);
    release_key();
    chk_judge("hold2_early_release", MISS, 7, 0);
    chk("hold2_active_clr", 32'(bus.hold_active), 0);

    // Hold start never pressed: skips its end entry
    advance_to(457);
    step();
    chk_judge("hold3_missed", MISS, 9, 0);
    chk("hold3_never_active", 32'(bus.hold_active), 0);

    advance_to(493);
    press();
    chk_judge("tap_early7_ignored", NONE, 9, 0);
    release_key();
    advance_to(494);
    press();
    chk_judge("tap_good_early6", GOOD, 10, 1);
    release_key();
    chk("lane_done_set", 32'(bus.lane_done), 1);
    press();
    chk("done_no_pulse", 32'(bus.judge_valid), 0);
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    chk("done_time_frozen", 32'(bus.song_time), 494);
    release_key();

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_judge("restart", NONE, 0, 0);
    chk("restart_time", 32'(bus.song_time), 0);
    chk("restart_done_clr", 32'(bus.lane_done), 0);

    // Asynchronous reset in the middle of a hold
    rom[0] = mk(2'b01, 5);
    rom[1] = mk(2'b10, 20);
    advance_to(5);
    press();
    chk_judge("hold4_start", PERFECT, 1, 1);
    #2 Reset_n = 1'b0;
    #1;
    chk_judge("async_rst", NONE, 0, 0);
    chk("async_rst_hold", 32'(bus.hold_active), 0);
    chk("async_rst_time", 32'(bus.song_time), 0);
    step();
    Reset_n = 1'b1;
    bus.frame_tick = 1'b1;
    step();
    step();
    bus.frame_tick = 1'b0;
    chk("post_rst_idle_time", 32'(bus.song_time), 0);
    chk("post_rst_hold", 32'(bus.hold_active), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
